vector_dot_mac: RTL

VECTOR_DOT_MAC -- requirements
Module: vector_dot_mac

---
 rtl/vector_dot_mac.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vector_dot_mac.sv
// Signed vector dot-product multiply-accumulate: LANES products per beat,
// NUM_ELEMENTS/LANES beats per operand pair, strobe/ack handshake on both sides.
module vector_dot_mac #(
  parameter int WORD_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 4,
  parameter int LANES        = 2,
  parameter int ACC_WIDTH    = 72,
  parameter int SATURATE     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WORD_WIDTH*NUM_ELEMENTS-1:0] row,
  input  logic [WORD_WIDTH*NUM_ELEMENTS-1:0] column,
  input  logic                               accumulate,
  input  logic                               in_stb,
  output logic                               in_ack,
  output logic [WORD_WIDTH-1:0]              out,
  output logic [ACC_WIDTH-1:0]               out_full,
  output logic                               overflow,
  output logic                               out_stb,
  input  logic                               out_ack,
  output logic                               busy
);

  localparam int VEC_W    = WORD_WIDTH * NUM_ELEMENTS;
  localparam int PROD_W   = 2 * WORD_WIDTH;
  localparam int BEATS    = (LANES > 0) ? (NUM_ELEMENTS / LANES) : 1;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHIFT    = WORD_WIDTH * LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (LANES < 1 || (NUM_ELEMENTS % LANES) != 0) begin : g_bad_lanes
    $error("vector_dot_mac: LANES must be >= 1 and divide NUM_ELEMENTS");
  end
  if (ACC_WIDTH < 2 * WORD_WIDTH) begin : g_bad_acc
    $error("vector_dot_mac: ACC_WIDTH must be at least 2*WORD_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_OUT
  } state_t;

  state_t                        r_state;
  logic [VEC_W-1:0]              r_row;
  logic [VEC_W-1:0]              r_col;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [BEAT_W-1:0]             r_beat;
  logic [WORD_WIDTH-1:0]         r_out;
  logic [ACC_WIDTH-1:0]          r_out_full;
  logic                          r_overflow;

  logic signed [ACC_WIDTH-1:0]   w_beat_sum;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;
  logic [ACC_WIDTH-WORD_WIDTH:0] w_acc_hi;
  logic                          w_ovf;
  logic [WORD_WIDTH-1:0]         w_out;

  // Operands shift down by one beat's worth of lanes, so the active lanes
  // always sit in the low bits and no element-index mux is needed.
  always_comb begin
    logic signed [WORD_WIDTH-1:0] v_a;
    logic signed [WORD_WIDTH-1:0] v_b;
    logic signed [PROD_W-1:0]     v_prod;
    logic signed [ACC_WIDTH-1:0]  v_ext;
    // NOTE: every combinational variable gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    w_beat_sum = '0;
    v_a        = '0;
    v_b        = '0;
    v_prod     = '0;
    v_ext      = '0;
    for (int l = 0; l < LANES; l++) begin
      v_a        = r_row[l*WORD_WIDTH +: WORD_WIDTH];
      v_b        = r_col[l*WORD_WIDTH +: WORD_WIDTH];
      v_prod     = PROD_W'(v_a) * PROD_W'(v_b);
      v_ext      = ACC_WIDTH'(v_prod);
      w_beat_sum = w_beat_sum + v_ext;
    end
  end

  assign w_acc_next = r_acc + w_beat_sum;

  // In range iff every bit from the word's sign bit upward agrees.
  assign w_acc_hi = w_acc_next[ACC_WIDTH-1:WORD_WIDTH-1];
  assign w_ovf    = !((&w_acc_hi) || (~|w_acc_hi));

  always_comb begin
    w_out = w_acc_next[WORD_WIDTH-1:0];
    if (SATURATE != 0 && w_ovf) begin
      w_out = w_acc_next[ACC_WIDTH-1] ? {1'b1, {(WORD_WIDTH-1){1'b0}}}
                                      : {1'b0, {(WORD_WIDTH-1){1'b1}}};
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: operand latches are reset too; they are a handful of flops, not
      // a RAM, and a defined value keeps the datapath free of X after reset.
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_acc      <= '0;
      r_beat     <= '0;
      r_out      <= '0;
      r_out_full <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_stb) begin
            r_row   <= row;
            r_col   <= column;
            r_beat  <= '0;
            r_state <= ST_MULT;
            if (!accumulate) begin
              r_acc <= '0;
            end
          end
        end
        ST_MULT: begin
          r_acc  <= w_acc_next;
          r_row  <= r_row >> SHIFT;
          r_col  <= r_col >> SHIFT;
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_out_full <= w_acc_next;
            r_overflow <= w_ovf;
            r_out      <= w_out;
            r_state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ack   = (r_state == ST_IDLE);
  assign out_stb  = (r_state == ST_OUT);
  assign busy     = (r_state != ST_IDLE);
  assign out      = r_out;
  assign out_full = r_out_full;
  assign overflow = r_overflow;

endmodule
